// File: rtl/sky_stacker_pkg.sv
// ============================================================================
//  Module  : sky_stacker_pkg
//  Brief   : Shared types, colour codes, screen limits and sprite defaults
//            for the sky-stacker game blocks.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sky_stacker_pkg;

    typedef enum logic [1:0] {
        COL_NONE = 2'b00,
        COL_C1   = 2'b01,
        COL_C2   = 2'b10,
        COL_C3   = 2'b11
    } color_t;

    typedef enum logic [1:0] {
        ST_TRACK  = 2'd0,
        ST_CAUGHT = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int ITEM_W_DEF  = 20;
    localparam int ITEM_H_DEF  = 15;
    localparam int BLOCK_H_DEF = 15;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s[9:8] != 2'b00) ? 8'hFF : s[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/color_stack.sv
// ============================================================================
//  Module  : color_stack
//  Brief   : MAX_STACK-deep 2-bit colour LIFO with push, clear, height and a
//            flat colour view (slot 0 = bottom, empty slots read 00).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module color_stack
    import sky_stacker_pkg::*;
#(
    parameter int MAX_STACK = 8
) (
    input  logic                     fall_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     clr,
    input  logic [1:0]               color_in,
    output logic [3:0]               height,
    output logic [2*MAX_STACK-1:0]   colors
);

    logic [3:0]             height_q, height_d;
    logic [2*MAX_STACK-1:0] colors_q, colors_d;

    // A push on a full stack is dropped; clear wins over push.
    always_comb begin
        height_d = height_q;
        colors_d = colors_q;
        if (clr) begin
            height_d = 4'd0;
            colors_d = '0;
        end else if (push && (height_q < 4'(MAX_STACK))) begin
            colors_d[2*height_q +: 2] = color_in;
            height_d                  = height_q + 4'd1;
        end
    end

    always_ff @(posedge fall_clk or posedge rst) begin
        if (rst) begin
            height_q <= 4'd0;
            colors_q <= '0;
        end else begin
            height_q <= height_d;
            colors_q <= colors_d;
        end
    end

    assign height = height_q;
    assign colors = colors_q;

endmodule

`default_nettype wire

// File: rtl/item_catcher.sv
// ============================================================================
//  Module  : item_catcher
//  Brief   : Catch/miss decision for the falling item against the platform and
//            stack; tracks stack, score, misses and game over.
//            Optional: define CATCH_BONUS_EN for the full-stack bonus and clear.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module item_catcher
    import sky_stacker_pkg::*;
#(
    parameter int ITEM_W    = ITEM_W_DEF,
    parameter int ITEM_H    = ITEM_H_DEF,
    parameter int PLAT_X_W  = 60,
    parameter int PLAT_Y    = 400,
    parameter int BLOCK_H   = BLOCK_H_DEF,
    parameter int MAX_STACK = 8,
    parameter int MAX_MISS  = 3
) (
    input  logic                     fall_clk,
    input  logic                     rst,
    input  logic                     pause,
    input  logic [9:0]               item_x,
    input  logic [9:0]               item_y,
    input  logic [1:0]               item_color,
    input  logic [9:0]               player_x,
    output logic                     collision,
    output logic [3:0]               stack_height,
    output logic [2*MAX_STACK-1:0]   stack_colors,
    output logic [7:0]               score,
    output logic [1:0]               misses,
    output logic                     game_over
);

    state_t      state_q, state_d;
    logic [9:0]  prev_y_q, prev_y_d;
    logic        armed_q, armed_d;
    logic        collision_q, collision_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  misses_q, misses_d;
    logic        game_over_q, game_over_d;

    logic        push, clr, full_clr;
    logic [3:0]  height;
    logic [10:0] catch_line;
    logic        hit_v, hit_h, respawn;
    logic [8:0]  catch_inc;
    logic        active;

    assign catch_line = 11'(PLAT_Y) - 11'(BLOCK_H) * 11'(height);
    assign hit_v      = ({1'b0, item_y} + 11'(ITEM_H)) >= catch_line;
    assign hit_h      = (({1'b0, item_x} + 11'(ITEM_W)) > {1'b0, player_x}) &&
                        ({1'b0, item_x} < ({1'b0, player_x} + 11'(PLAT_X_W)));
    assign respawn    = item_y < prev_y_q;
    assign active     = !pause && (state_q != ST_OVER);

`ifdef CATCH_BONUS_EN
    // The catch that fills the stack earns the bonus; the stack empties on the next tick.
    assign catch_inc = (height == 4'(MAX_STACK - 1)) ? 9'(1 + MAX_STACK) : 9'd1;
    assign full_clr  = (height == 4'(MAX_STACK));
`else
    assign catch_inc = 9'd1;
    assign full_clr  = 1'b0;
`endif

    assign clr = active && full_clr;

    always_comb begin
        state_d     = state_q;
        prev_y_d    = prev_y_q;
        armed_d     = armed_q;
        collision_d = 1'b0;
        score_d     = score_q;
        misses_d    = misses_q;
        push        = 1'b0;
        if (active) begin
            prev_y_d = item_y;
            case (state_q)
                ST_TRACK: begin
                    if (respawn) begin
                        armed_d = 1'b1;
                    end
                    // An uncaught drop ending takes priority over a catch on the same sample.
                    if (respawn && armed_q) begin
                        misses_d = misses_q + 2'd1;
                        if (misses_d == 2'(MAX_MISS)) begin
                            state_d = ST_OVER;
                        end
                    end else if (hit_v && hit_h) begin
                        state_d     = ST_CAUGHT;
                        collision_d = 1'b1;
                        push        = 1'b1;
                        score_d     = sat_add8(score_q, catch_inc);
                    end
                end
                ST_CAUGHT: begin
                    if (respawn) begin
                        state_d = ST_TRACK;
                        armed_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge fall_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_TRACK;
            prev_y_q    <= 10'd0;
            armed_q     <= 1'b0;
            collision_q <= 1'b0;
            score_q     <= 8'd0;
            misses_q    <= 2'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_y_q    <= prev_y_d;
            armed_q     <= armed_d;
            collision_q <= collision_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            game_over_q <= game_over_d;
        end
    end

    color_stack #(
        .MAX_STACK (MAX_STACK)
    ) u_color_stack (
        .fall_clk  (fall_clk),
        .rst       (rst),
        .push      (push),
        .clr       (clr),
        .color_in  (item_color),
        .height    (height),
        .colors    (stack_colors)
    );

    assign collision    = collision_q;
    assign stack_height = height;
    assign score        = score_q;
    assign misses       = misses_q;
    assign game_over    = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_item_catcher.sv
// ============================================================================
//  Module  : tb_item_catcher
//  Brief   : Self-checking bench for item_catcher against a game-level model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_item_catcher;

    localparam int MAXS  = 8;
`ifdef CATCH_BONUS_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic             fall_clk = 1'b0;
    logic             rst;
    logic             pause;
    logic [9:0]       item_x, item_y, player_x;
    logic [1:0]       item_color;
    logic             collision;
    logic [3:0]       stack_height;
    logic [2*MAXS-1:0] stack_colors;
    logic [7:0]       score;
    logic [1:0]       misses;
    logic             game_over;

    item_catcher dut (
        .fall_clk     (fall_clk),
        .rst          (rst),
        .pause        (pause),
        .item_x       (item_x),
        .item_y       (item_y),
        .item_color   (item_color),
        .player_x     (player_x),
        .collision    (collision),
        .stack_height (stack_height),
        .stack_colors (stack_colors),
        .score        (score),
        .misses       (misses),
        .game_over    (game_over)
    );

    always #5 fall_clk = ~fall_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Game-level reference: this drop caught or not, game over or not.
    int m_height, m_score, m_misses, m_prev;
    int m_col[MAXS];
    bit m_coll, m_over, m_caught_drop, m_had_drop;

    function automatic int m_colors_flat();
        int f = 0;
        for (int i = 0; i < MAXS; i++) f += m_col[i] << (2 * i);
        return f;
    endfunction

    task automatic model_reset();
        m_height = 0; m_score = 0; m_misses = 0; m_prev = 0;
        for (int i = 0; i < MAXS; i++) m_col[i] = 0;
        m_coll = 0; m_over = 0; m_caught_drop = 0; m_had_drop = 0;
    endtask

    task automatic model_step();
        int  y, cl;
        bit  new_drop, missed;
        m_coll = 0;
        if (pause || m_over) return;
        if (BONUS && m_height == MAXS) begin
            m_height = 0;
            for (int i = 0; i < MAXS; i++) m_col[i] = 0;
        end
        y        = int'(item_y);
        new_drop = (y < m_prev);
        m_prev   = y;
        missed   = 0;
        if (new_drop) begin
            if (m_had_drop && !m_caught_drop) begin
                m_misses++;
                missed = 1;
                if (m_misses == 3) m_over = 1;
            end
            m_had_drop    = 1;
            if (m_caught_drop) begin
                m_caught_drop = 0;
                return;
            end
        end
        if (missed || m_caught_drop) return;
        cl = 400 - 15 * m_height;
        if ((y + 15 >= cl) && (int'(item_x) + 20 > int'(player_x)) &&
            (int'(item_x) < int'(player_x) + 60)) begin
            m_coll        = 1;
            m_caught_drop = 1;
            if (m_height < MAXS) begin
                m_score += (BONUS && m_height == MAXS - 1) ? 1 + MAXS : 1;
                m_col[m_height] = int'(item_color);
                m_height++;
            end else begin
                m_score += 1;
            end
            if (m_score > 255) m_score = 255;
        end
    endtask

    task automatic compare_all();
        check("collision",    int'(collision),    int'(m_coll));
        check("stack_height", int'(stack_height), m_height);
        check("stack_colors", int'(stack_colors), m_colors_flat());
        check("score",        int'(score),        m_score);
        check("misses",       int'(misses),       m_misses);
        check("game_over",    int'(game_over),    int'(m_over));
    endtask

    task automatic tick(input int y);
        item_y = 10'(y);
        @(posedge fall_clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    task automatic drop(input int ix, input int px, input int col,
                        input int y0, input int y1, input bit rnd_pause);
        item_x     = 10'(ix);
        player_x   = 10'(px);
        item_color = 2'(col);
        for (int y = y0; y <= y1; y += 15) begin
            if (rnd_pause) pause = ($urandom_range(0, 9) == 0);
            tick(y);
        end
        pause = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pause = 1'b0;
        item_x = '0; item_y = '0; player_x = '0; item_color = 2'd1;
        model_reset();
        @(posedge fall_clk); #1;
        do_reset();

        // Basic catch at y=390, then stacked catch at y=375.
        drop(110, 100, 2, 0, 390, 0);
        check("t1_collision", int'(collision), 1);
        check("t1_height", int'(stack_height), 1);
        check("t1_slot0", int'(stack_colors[1:0]), 2);
        check("t1_score", int'(score), 1);
        drop(110, 100, 1, 0, 375, 0);
        check("t2_collision", int'(collision), 1);
        check("t2_height", int'(stack_height), 2);

        // Three misses end the game; later in-window drops do nothing.
        drop(300, 100, 3, 0, 405, 0);
        item_x = 10'd300;
        tick(0);
        check("t3_misses", int'(misses), 1);
        check("t3_collision", int'(collision), 0);
        drop(300, 100, 3, 15, 405, 0);
        tick(0);
        check("t4_misses2", int'(misses), 2);
        drop(300, 100, 3, 15, 405, 0);
        tick(0);
        check("t4_game_over", int'(game_over), 1);
        drop(110, 100, 1, 15, 405, 0);
        check("t4_frozen_score", int'(score), 2);
        check("t4_frozen_height", int'(stack_height), 2);

        // Pause across the catching sample.
        do_reset();
        drop(110, 100, 2, 0, 375, 0);
        pause = 1'b1;
        tick(390);
        check("t5_paused", int'(collision), 0);
        tick(390);
        check("t5_paused2", int'(collision), 0);
        pause = 1'b0;
        tick(390);
        check("t5_release", int'(collision), 1);

        // Full-stack behaviour.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drop(110, 100, (k % 3) + 1, 0, 465, 0);
            if (BONUS && k == 7) begin
                check("t6_bonus_score", int'(score), 16);
                check("t6_bonus_clear", int'(stack_height), 0);
            end
            if (!BONUS && k == 8) begin
                check("t6_full_score", int'(score), 9);
                check("t6_full_height", int'(stack_height), 8);
            end
        end

        // Reset mid-drop discards the drop: no miss on next respawn.
        drop(300, 100, 1, 0, 200, 0);
        do_reset();
        check("t7_reset_score", int'(score), 0);
        drop(300, 100, 1, 215, 405, 0);
        tick(0);
        check("t7_no_miss", int'(misses), 0);
        drop(300, 100, 1, 15, 405, 0);
        tick(0);
        check("t7_armed_miss", int'(misses), 1);

        // Randomized play.
        do_reset();
        for (int d = 0; d < 80; d++) begin
            int px, ix;
            if ($urandom_range(0, 7) == 0) do_reset();
            px = $urandom_range(0, 560);
            ix = px + $urandom_range(0, 140) - 50;
            if (ix < 0) ix = 0;
            if (ix > 620) ix = 620;
            drop(ix, px, $urandom_range(1, 3), $urandom_range(0, 14),
                 $urandom_range(380, 470), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
